// File: rtl/correlator_framer_pkg.sv
// -----------------------------------------------------------------------------
// correlator_framer_pkg
// Shared constants for the correlator TX framer:
//   - frame-state encoding (legacy-compatible localparam constants)
//   - header/footer widths, sync byte, CRC-16/CCITT-FALSE constants
//   - payload_size(): derives the correlator+counter payload width from the
//     correlator configuration, reused by the top level for the payload port.
// -----------------------------------------------------------------------------
package correlator_framer_pkg;

  typedef logic [2:0] frame_state_t;

  localparam frame_state_t ST_IDLE    = 3'd0;
  localparam frame_state_t ST_SYNC    = 3'd1;
  localparam frame_state_t ST_HEADER  = 3'd2;
  localparam frame_state_t ST_PAYLOAD = 3'd3;
  localparam frame_state_t ST_FOOTER  = 3'd4;
  localparam frame_state_t ST_CRC     = 3'd5;
  localparam frame_state_t ST_EOL     = 3'd6;

  localparam int HEADER_SIZE = 64;
  localparam int FOOTER_SIZE = 64;
  localparam int SYNC_LEN    = 8;

  localparam logic [15:0] CRC_POLY  = 16'h1021;
  localparam logic [15:0] CRC_INIT  = 16'hFFFF;
  localparam logic [7:0]  SYNC_BYTE = 8'hFF;
  localparam logic [7:0]  ASCII_CR  = 8'h0D;
  localparam logic [7:0]  ASCII_LF  = 8'h0A;

  // Cross terms (one per input pair per lag), auto terms, both as real/imag
  // pairs, plus one counter word per input.
  function automatic int payload_size(input int num_inputs, input int lag_auto,
                                      input int lag_cross, input int has_cross,
                                      input int resolution);
    return ((has_cross * num_inputs * (num_inputs - 1) / 2 * (2 * lag_cross - 1)
             + num_inputs * lag_auto) * 2 + num_inputs) * resolution;
  endfunction

endpackage

// File: rtl/correlator_framer_if.sv
// -----------------------------------------------------------------------------
// correlator_framer_if
// Byte stream from the framer to the UART/SPI byte transmitter.
//   tx_data  : outgoing byte (framer -> transmitter)
//   tx_valid : tx_data valid  (framer -> transmitter)
//   tx_ready : transmitter accepts the byte (transmitter -> framer)
// A byte moves on any cycle where tx_valid & tx_ready.
// -----------------------------------------------------------------------------
interface correlator_framer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/correlator_framer_crc16_byte.sv
// -----------------------------------------------------------------------------
// crc16_byte
// Combinational CRC-16/CCITT-FALSE update for one byte, MSB first.
//   i_crc  : current CRC register
//   i_byte : byte being absorbed
//   o_crc  : CRC after absorbing i_byte
// -----------------------------------------------------------------------------
module crc16_byte
  import correlator_framer_pkg::*;
(
  input  logic [15:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_crc
);

  always_comb begin
    logic [15:0] c;
    c = i_crc;
    for (int i = 7; i >= 0; i--) begin
      // Feedback is the outgoing CRC bit XOR the incoming data bit.
      c = {c[14:0], 1'b0} ^ (((c[15] ^ i_byte[i]) == 1'b1) ? CRC_POLY : 16'h0000);
    end
    o_crc = c;
  end

endmodule

// File: rtl/correlator_framer.sv
// -----------------------------------------------------------------------------
// correlator_framer
// Snapshots the correlator/counter payload and a 64-bit timestamp, then
// streams  [sync] | header | payload | timestamp | CRC-16 | [CR LF]
// byte-wise over a valid/ready handshake, either as raw bytes or as
// hex-ASCII characters (two per byte, high nibble first).
//
// Ports:
//   intclk     : framer clock
//   enable     : asynchronous active-low reset
//   capture    : integration level; a 0->1 edge arms the sync word
//   snap_valid : one-cycle strobe, payload/timestamp valid
//   payload    : correlator + counter words, MSB first on the wire
//   timestamp  : footer timestamp
//   tx         : byte stream to the transmitter (master side)
//   busy       : frame in progress
//   overrun    : saturating count of snapshots dropped while busy
// -----------------------------------------------------------------------------
module correlator_framer
  import correlator_framer_pkg::*;
#(
  parameter int          NUM_INPUTS          = 8,
  parameter int          LAG_AUTO            = 1,
  parameter int          LAG_CROSS           = 1,
  parameter int          DELAY_SIZE          = 0,
  parameter int          RESOLUTION          = 24,
  parameter int          HAS_CROSSCORRELATOR = 1,
  parameter logic [3:0]  FLAGS               = 4'b0011,
  parameter logic [15:0] TICK                = 16'd0,
  parameter bit          BINARY              = 1'b0,
  localparam int PAYLOAD_SIZE = payload_size(NUM_INPUTS, LAG_AUTO, LAG_CROSS,
                                             HAS_CROSSCORRELATOR, RESOLUTION)
) (
  input  logic                    intclk,
  input  logic                    enable,
  input  logic                    capture,
  input  logic                    snap_valid,
  input  logic [PAYLOAD_SIZE-1:0] payload,
  input  logic [63:0]             timestamp,
  correlator_framer_if.master     tx,
  output logic                    busy,
  output logic [7:0]              overrun
);

  localparam int PAYLOAD_BYTES = PAYLOAD_SIZE / 8;
  localparam int FRAME_W       = HEADER_SIZE + PAYLOAD_SIZE + FOOTER_SIZE;

  localparam logic [63:0] HEADER_WORD = {8'(RESOLUTION), 8'(NUM_INPUTS - 1),
                                         12'(DELAY_SIZE), 8'(LAG_AUTO - 1),
                                         8'(LAG_CROSS - 1), FLAGS, TICK};

  generate
    if ((RESOLUTION % 8) != 0) begin : g_res_check
      $error("correlator_framer: RESOLUTION must be a multiple of 8");
    end
  endgenerate

  frame_state_t         r_state;
  logic [15:0]          r_cnt;
  logic                 r_nib;      // ASCII: 0 = high-nibble char pending
  logic [FRAME_W-1:0]   r_frame;    // header|payload|timestamp, shifted out MSB first
  logic [15:0]          r_crc;
  logic                 r_cap_q;
  logic                 r_armed;
  logic [7:0]           r_overrun;

  logic                 w_xfer;
  logic                 w_byte_done;
  logic                 w_body;
  logic                 w_cnt_end;
  logic                 w_last;
  logic                 w_rise;
  logic                 w_accept;
  logic                 w_drop;
  logic [15:0]          w_end_cnt;
  frame_state_t         w_next_state;
  logic [7:0]           w_byte;
  logic [3:0]           w_nib;
  logic [7:0]           w_char;
  logic [7:0]           w_tx_data;
  logic [15:0]          w_crc_next;

  assign w_xfer      = tx.tx_valid & tx.tx_ready;
  // In ASCII mode a byte is complete only after its low-nibble character;
  // EOL characters are sent raw.
  assign w_byte_done = w_xfer & (BINARY | r_nib | (r_state == ST_EOL));
  assign w_body      = (r_state == ST_HEADER) | (r_state == ST_PAYLOAD) |
                       (r_state == ST_FOOTER);
  assign w_cnt_end   = (r_cnt == w_end_cnt);
  assign w_last      = w_byte_done & w_cnt_end &
                       (((r_state == ST_CRC) & BINARY) | (r_state == ST_EOL));
  assign w_rise      = capture & ~r_cap_q;
  // A snap coinciding with the final transfer starts the next frame at once.
  assign w_accept    = snap_valid & capture & ((r_state == ST_IDLE) | w_last);
  assign w_drop      = snap_valid & capture & (r_state != ST_IDLE) & ~w_last;

  always_comb begin
    w_end_cnt    = 16'd1;
    w_next_state = ST_IDLE;
    case (r_state)
      ST_SYNC: begin
        w_end_cnt    = 16'(SYNC_LEN - 1);
        w_next_state = ST_HEADER;
      end
      ST_HEADER: begin
        w_end_cnt    = 16'(HEADER_SIZE / 8 - 1);
        w_next_state = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        w_end_cnt    = 16'(PAYLOAD_BYTES - 1);
        w_next_state = ST_FOOTER;
      end
      ST_FOOTER: begin
        w_end_cnt    = 16'(FOOTER_SIZE / 8 - 1);
        w_next_state = ST_CRC;
      end
      ST_CRC: begin
        w_end_cnt    = 16'd1;
        w_next_state = BINARY ? ST_IDLE : ST_EOL;
      end
      ST_EOL: begin
        w_end_cnt    = 16'd1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_end_cnt    = 16'd1;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      ST_SYNC:                          w_byte = SYNC_BYTE;
      ST_HEADER, ST_PAYLOAD, ST_FOOTER: w_byte = r_frame[FRAME_W-1 -: 8];
      ST_CRC:                           w_byte = (r_cnt == 16'd0) ? r_crc[15:8] : r_crc[7:0];
      default:                          w_byte = 8'h00;
    endcase
  end

  assign w_nib  = r_nib ? w_byte[3:0] : w_byte[7:4];
  assign w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});

  always_comb begin
    w_tx_data = 8'h00;
    if (r_state == ST_IDLE) begin
      w_tx_data = 8'h00;
    end else if (BINARY) begin
      w_tx_data = w_byte;
    end else if (r_state == ST_EOL) begin
      w_tx_data = (r_cnt == 16'd0) ? ASCII_CR : ASCII_LF;
    end else begin
      w_tx_data = w_char;
    end
  end

  crc16_byte u_crc (
    .i_crc  (r_crc),
    .i_byte (w_byte),
    .o_crc  (w_crc_next)
  );

  always_ff @(posedge intclk or negedge enable) begin
    if (!enable) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 16'd0;
      r_nib     <= 1'b0;
      r_frame   <= '0;
      r_crc     <= CRC_INIT;
      // Held high so a capture level already high out of reset does not
      // count as a rising edge.
      r_cap_q   <= 1'b1;
      r_armed   <= 1'b0;
      r_overrun <= 8'h00;
    end else begin
      r_cap_q <= capture;
      r_armed <= w_accept ? 1'b0 : (r_armed | w_rise);

      if (w_drop && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end

      if (w_accept) begin
        r_state <= (r_armed | w_rise) ? ST_SYNC : ST_HEADER;
        r_cnt   <= 16'd0;
        r_nib   <= 1'b0;
        r_crc   <= CRC_INIT;
        r_frame <= {HEADER_WORD, payload, timestamp};
      end else begin
        if (w_xfer && !BINARY && (r_state != ST_EOL)) begin
          r_nib <= ~r_nib;
        end
        if (w_byte_done) begin
          if (w_body) begin
            r_crc   <= w_crc_next;
            r_frame <= r_frame << 8;
          end
          if (w_cnt_end) begin
            r_state <= w_next_state;
            r_cnt   <= 16'd0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
      end
    end
  end

  assign tx.tx_valid = (r_state != ST_IDLE);
  assign tx.tx_data  = w_tx_data;
  assign busy        = (r_state != ST_IDLE);
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_correlator_framer.sv
module tb_correlator_framer;

  localparam logic [63:0] HDR = 64'h0801_0000_0003_0000;
  localparam logic [63:0] P1  = 64'h0102030405060708;
  localparam logic [63:0] T1  = 64'h00000000000000A5;
  localparam logic [63:0] P2  = 64'h1112131415161718;
  localparam logic [63:0] T2  = 64'h0123456789ABCDEF;
  localparam logic [63:0] P3  = 64'hF0E1D2C3B4A59687;
  localparam logic [63:0] T3  = 64'hFEDCBA9876543210;

  logic        intclk = 1'b0;
  logic        enable, capture, snap_b, snap_a;
  logic [63:0] payload, timestamp;
  logic        busy_b, busy_a;
  logic [7:0]  ovr_b, ovr_a;
  int          rdy_mode;
  int          tests = 0;
  int          fails = 0;

  logic [7:0]  qb[$];
  logic [7:0]  qa[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  expa_q[$];

  logic        pv = 1'b0, pr = 1'b0;
  logic [7:0]  pd = 8'h00;

  always #5 intclk = ~intclk;

  correlator_framer_if if_b ();
  correlator_framer_if if_a ();

  correlator_framer #(
    .NUM_INPUTS(2), .LAG_AUTO(1), .LAG_CROSS(1), .DELAY_SIZE(0), .RESOLUTION(8),
    .HAS_CROSSCORRELATOR(1), .FLAGS(4'b0011), .TICK(16'd0), .BINARY(1'b1)
  ) u_bin (
    .intclk(intclk), .enable(enable), .capture(capture), .snap_valid(snap_b),
    .payload(payload), .timestamp(timestamp), .tx(if_b), .busy(busy_b), .overrun(ovr_b)
  );

  correlator_framer #(
    .NUM_INPUTS(2), .LAG_AUTO(1), .LAG_CROSS(1), .DELAY_SIZE(0), .RESOLUTION(8),
    .HAS_CROSSCORRELATOR(1), .FLAGS(4'b0011), .TICK(16'd0), .BINARY(1'b0)
  ) u_asc (
    .intclk(intclk), .enable(enable), .capture(capture), .snap_valid(snap_a),
    .payload(payload), .timestamp(timestamp), .tx(if_a), .busy(busy_a), .overrun(ovr_a)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] x;
    x = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  // Appends one frame's raw bytes to exp_q.
  task automatic build_exp(input bit sync, input logic [63:0] pl, input logic [63:0] ts);
    logic [15:0] c;
    logic [191:0] body;
    c = 16'hFFFF;
    body = {HDR, pl, ts};
    if (sync) for (int i = 0; i < 8; i++) exp_q.push_back(8'hFF);
    for (int i = 23; i >= 0; i--) begin
      exp_q.push_back(body[i*8 +: 8]);
      c = crc_model(c, body[i*8 +: 8]);
    end
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
  endtask

  task automatic build_ascii();
    expa_q = {};
    foreach (exp_q[i]) begin
      expa_q.push_back(hex_char(exp_q[i][7:4]));
      expa_q.push_back(hex_char(exp_q[i][3:0]));
    end
    expa_q.push_back(8'h0D);
    expa_q.push_back(8'h0A);
  endtask

  task automatic cmp_frame(input string tag, input int which);
    logic [7:0] got[$];
    logic [7:0] exp[$];
    if (which == 0) begin got = qb; exp = exp_q; end
    else begin got = qa; exp = expa_q; end
    check({tag, "_len"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
  endtask

  task step();
    @(posedge intclk);
    #1;
  endtask

  task automatic wait_frame(input string tag, input int which, input int n, input int budget);
    int k;
    k = 0;
    while ((((which == 0) ? qb.size() : qa.size()) < n) && (k < budget)) begin
      step();
      k++;
    end
    repeat (3) step();
    check({tag, "_idle"}, (which == 0) ? busy_b : busy_a, 1'b0);
  endtask

  task automatic snap_bin(input logic [63:0] pl, input logic [63:0] ts);
    payload = pl; timestamp = ts; snap_b = 1'b1;
    step();
    snap_b = 1'b0; payload = '1; timestamp = '1;
  endtask

  // Ready driver: 0 = held low, 1 = held high, 2 = random.
  initial begin
    if_b.tx_ready = 1'b1;
    forever begin
      @(posedge intclk);
      #1;
      if_b.tx_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  end

  // Byte collector and stall-stability monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge intclk);
      if (enable) begin
        if (if_b.tx_valid && if_b.tx_ready) qb.push_back(if_b.tx_data);
        if (if_a.tx_valid && if_a.tx_ready) qa.push_back(if_a.tx_data);
        if (pv && !pr) begin
          check("hold_valid", if_b.tx_valid, 1'b1);
          check("hold_data", if_b.tx_data, pd);
        end
      end
      pv = if_b.tx_valid & enable;
      pr = if_b.tx_ready;
      pd = if_b.tx_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    enable = 1'b0; capture = 1'b0; snap_b = 1'b0; snap_a = 1'b0;
    payload = '0; timestamp = '0; rdy_mode = 1; if_a.tx_ready = 1'b1;
    repeat (3) step();
    check("rst_valid_b", if_b.tx_valid, 1'b0);
    check("rst_data_b", if_b.tx_data, 8'h00);
    check("rst_busy_b", busy_b, 1'b0);
    check("rst_ovr_b", ovr_b, 8'h00);
    check("rst_valid_a", if_a.tx_valid, 1'b0);
    check("rst_ovr_a", ovr_a, 8'h00);
    enable = 1'b1; step();
    capture = 1'b1; step();

    // Frame 1: first snap after capture edge carries the sync word.
    qb = {};
    payload = P1; timestamp = T1; snap_b = 1'b1;
    check("pre_accept_valid", if_b.tx_valid, 1'b0);
    step();
    snap_b = 1'b0; payload = '1; timestamp = '1;
    check("latency_valid", if_b.tx_valid, 1'b1);
    check("latency_busy", busy_b, 1'b1);
    wait_frame("f1", 0, 34, 200);
    exp_q = {}; build_exp(1'b1, P1, T1);
    cmp_frame("f1", 0);

    // Frame 2: capture still high, no sync.
    qb = {};
    snap_bin(P2, T2);
    wait_frame("f2", 0, 26, 200);
    exp_q = {}; build_exp(1'b0, P2, T2);
    cmp_frame("f2", 0);

    // Frame 3: random back-pressure, same bytes as frame 2.
    qb = {}; rdy_mode = 2;
    snap_bin(P2, T2);
    wait_frame("f3", 0, 26, 1000);
    rdy_mode = 1;
    cmp_frame("f3", 0);

    // ASCII mode: sync frame then plain frame.
    qa = {};
    payload = P1; timestamp = T1; snap_a = 1'b1; step(); snap_a = 1'b0;
    wait_frame("a1", 1, 70, 300);
    exp_q = {}; build_exp(1'b1, P1, T1); build_ascii();
    cmp_frame("a1", 1);
    check("a1_hdr_hi", qa[16], 8'h30);
    check("a1_hdr_lo", qa[17], 8'h38);
    qa = {};
    payload = P2; timestamp = T2; snap_a = 1'b1; step(); snap_a = 1'b0;
    wait_frame("a2", 1, 54, 300);
    exp_q = {}; build_exp(1'b0, P2, T2); build_ascii();
    cmp_frame("a2", 1);

    // Snap coinciding with the last byte: accepted, back-to-back frame.
    qb = {};
    snap_bin(P2, T2);
    k = 0;
    while (qb.size() < 25 && k < 200) begin step(); k++; end
    payload = P3; timestamp = T3; snap_b = 1'b1;
    step();
    snap_b = 1'b0; payload = '1; timestamp = '1;
    check("b2b_valid", if_b.tx_valid, 1'b1);
    check("b2b_busy", busy_b, 1'b1);
    check("b2b_ovr", ovr_b, 8'h00);
    wait_frame("b2b", 0, 52, 300);
    exp_q = {}; build_exp(1'b0, P2, T2); build_exp(1'b0, P3, T3);
    cmp_frame("b2b", 0);

    // Three snaps while busy are dropped and counted.
    qb = {};
    snap_bin(P1, T1);
    payload = P3; timestamp = T3;
    for (int i = 0; i < 3; i++) begin
      snap_b = 1'b1; step(); snap_b = 1'b0; step();
    end
    check("ovr_3", ovr_b, 8'd3);
    wait_frame("ovr", 0, 26, 200);
    exp_q = {}; build_exp(1'b0, P1, T1);
    cmp_frame("ovr", 0);

    // Snap with capture low is ignored entirely.
    capture = 1'b0; step();
    snap_b = 1'b1; step(); snap_b = 1'b0; step();
    check("cap0_valid", if_b.tx_valid, 1'b0);
    check("cap0_ovr", ovr_b, 8'd3);

    // Capture re-rises (sync), stall the stream and flood with snaps.
    capture = 1'b1; step();
    qb = {}; rdy_mode = 0;
    payload = P2; timestamp = T2; snap_b = 1'b1;
    step();
    payload = '1; timestamp = '1;
    repeat (300) step();
    snap_b = 1'b0;
    check("ovr_sat", ovr_b, 8'hFF);
    rdy_mode = 1;
    wait_frame("sat", 0, 34, 200);
    exp_q = {}; build_exp(1'b1, P2, T2);
    cmp_frame("sat", 0);

    // Async reset at payload byte 3.
    qb = {};
    snap_bin(P1, T1);
    k = 0;
    while (qb.size() < 11 && k < 200) begin step(); k++; end
    enable = 1'b0;
    #1;
    check("arst_valid", if_b.tx_valid, 1'b0);
    check("arst_busy", busy_b, 1'b0);
    check("arst_ovr", ovr_b, 8'h00);
    check("arst_data", if_b.tx_data, 8'h00);
    step();
    enable = 1'b1; step();
    qb = {};
    snap_bin(P2, T2);
    wait_frame("post_rst", 0, 26, 200);
    exp_q = {}; build_exp(1'b0, P2, T2);
    cmp_frame("post_rst", 0);
    capture = 1'b0; step();
    capture = 1'b1; step();
    qb = {};
    snap_bin(P3, T3);
    wait_frame("rearm", 0, 34, 200);
    exp_q = {}; build_exp(1'b1, P3, T3);
    cmp_frame("rearm", 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
